// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: decode strobes, jump target and PC/status bundle between
// the instruction decoder (master) and the program-counter sequencer (slave).
interface pc_sequencer_if;
  logic        stall;
  logic        jump;
  logic        is_cond;
  logic        is_jmp;
  logic        is_call;
  logic        is_ret;
  logic [15:0] target;
  logic [15:0] pc;
  logic [15:0] pc_plus1;
  logic        taken;
  logic        stk_ovf;
  logic        stk_unf;

  modport master (
    output stall, jump, is_cond, is_jmp, is_call, is_ret, target,
    input  pc, pc_plus1, taken, stk_ovf, stk_unf
  );

  modport slave (
    input  stall, jump, is_cond, is_jmp, is_call, is_ret, target,
    output pc, pc_plus1, taken, stk_ovf, stk_unf
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program counter with priority next-PC selection
// (return, call, jump, qualified conditional jump, increment).
// Optional feature macro: PC_RET_STACK_EN enables the hardware return-address
// stack and its sticky overflow/underflow flags. Without it, call acts as an
// unconditional jump, return is ignored, and both flags read 0.
module pc_sequencer #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          STACK_DEPTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);

  // Reject unsupported depths at elaboration time.
  if (STACK_DEPTH < 2 || STACK_DEPTH > 16 ||
      (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pc_sequencer: STACK_DEPTH must be a power of two in 2..16");
  end

  logic [15:0] pc_q, pc_d;
  logic [15:0] pc_plus1;
  logic        taken;

  assign pc_plus1 = pc_q + 16'd1;

`ifdef PC_RET_STACK_EN
  localparam int PTR_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = $clog2(STACK_DEPTH);

  logic [15:0]      stk_mem_q [STACK_DEPTH];
  logic [PTR_W-1:0] sp_q;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             stk_full, stk_empty;
  logic             push, pop, set_ovf, set_unf;
  logic             ovf_q, unf_q;

  // Pointer counts occupied entries; the top entry sits one below it.
  assign stk_full  = (sp_q == PTR_W'(STACK_DEPTH));
  assign stk_empty = (sp_q == '0);
  assign wr_idx    = sp_q[IDX_W-1:0];
  assign rd_idx    = wr_idx - IDX_W'(1);
`endif

  // Next-PC selection and stack control, by strobe priority.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    pc_d  = pc_q;
    taken = 1'b0;
`ifdef PC_RET_STACK_EN
    push    = 1'b0;
    pop     = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
`endif
    if (!bus.stall) begin
      pc_d = pc_plus1;
`ifdef PC_RET_STACK_EN
      if (bus.is_ret) begin
        if (!stk_empty) begin
          pop   = 1'b1;
          pc_d  = stk_mem_q[rd_idx];
          taken = 1'b1;
        end else begin
          set_unf = 1'b1;
        end
      end else if (bus.is_call) begin
        pc_d  = bus.target;
        taken = 1'b1;
        if (!stk_full) push    = 1'b1;
        else           set_ovf = 1'b1;
      end else
`endif
      if (bus.is_call || bus.is_jmp || (bus.is_cond && bus.jump)) begin
        pc_d  = bus.target;
        taken = 1'b1;
      end
    end
  end

  // PC register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with <= so every register samples pre-edge values.
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

`ifdef PC_RET_STACK_EN
  // Stack pointer and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (push)    sp_q  <= sp_q + PTR_W'(1);
      else if (pop) sp_q <= sp_q - PTR_W'(1);
      if (set_ovf) ovf_q <= 1'b1;
      if (set_unf) unf_q <= 1'b1;
    end
  end

  // Return-address storage written on push.
  always_ff @(posedge clk) begin
    // NOTE: contents are meaningless once the pointer is reset, so the array carries no reset.
    if (push && !reset) stk_mem_q[wr_idx] <= pc_plus1;
  end

  assign bus.stk_ovf = ovf_q;
  assign bus.stk_unf = unf_q;
`else
  assign bus.stk_ovf = 1'b0;
  assign bus.stk_unf = 1'b0;
`endif

  assign bus.pc       = pc_q;
  assign bus.pc_plus1 = pc_plus1;
  assign bus.taken    = taken;

endmodule
